// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data requests win; fetches killed by a branch are drained and discarded.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                dm_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;   // 0 = fetch, 1 = data
    logic                kill_q, kill_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                fetch_kill;
    logic                deliver;
    logic [DATA_W-1:0]   deliver_data;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            kill_q  <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            kill_q  <= kill_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        kill_d       = kill_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        mem_req      = 1'b0;
        deliver      = 1'b0;
        deliver_data = '0;
        dm_done      = 1'b0;
        // A flush only ever concerns the fetch owner.
        fetch_kill   = if_flush && !owner_q;

        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (dm_req) begin
                    owner_d = 1'b1;
                    addr_d  = dm_addr;
                    we_d    = dm_we;
                    be_d    = dm_be;
                    wdata_d = dm_wdata;
                    state_d = S_ADDR;
                end else if (if_req && !if_flush) begin
                    owner_d = 1'b0;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    be_d    = '1;
                    wdata_d = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                mem_req = 1'b1;
                if (fetch_kill) kill_d = 1'b1;
                if (mem_gnt) begin
                    cnt_d = '0;
                    if (we_q) begin
                        dm_done = 1'b1;
                        kill_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = (kill_q || fetch_kill) ? S_DRAIN : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A flush coinciding with the response drains it on the spot.
                if (mem_rvalid) begin
                    deliver      = !fetch_kill;
                    deliver_data = mem_rdata;
                    kill_d       = 1'b0;
                    state_d      = S_IDLE;
                end else if (fetch_kill) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    deliver = 1'b1;
                    kill_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    kill_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (deliver && owner_q) dm_done = 1'b1;
    end

    assign if_done   = deliver && !owner_q;
    assign if_rdata  = if_done ? deliver_data : '0;
    assign dm_rdata  = (deliver && owner_q) ? deliver_data : '0;
    assign if_stall  = if_req && !if_done;
    assign dm_stall  = dm_req && !dm_done;
    assign mem_we    = mem_req && we_q;
    assign mem_be    = mem_req ? be_q : '0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule
